// File: rtl/raymarch_pkg.sv
// Shared definitions for the raymarcher frame pipeline.
//   sched_state_t  : pixel scheduler FSM states
//   COORD_W        : width of the raymarcher pixel coordinates
//   WDOG_W         : width of the per-pixel watchdog counter
//   COLOR_MAGENTA  : colour written when a pixel times out
//   rgb888_to_565  : truncating RGB888 -> RGB565 packer
package raymarch_pkg;

  localparam int COORD_W = 33;
  localparam int WDOG_W  = 17;

  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } sched_state_t;

  // Keeps the top bits of each channel: R[7:3], G[7:2], B[7:3].
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] color);
    return {color[23:19], color[15:10], color[7:3]};
  endfunction

endpackage

// File: rtl/ray_pixel_scheduler_if.sv
// Bundle of every non-clock signal of ray_pixel_scheduler.
//   frame control : frame_start_in, busy_out, frame_done_out, buffer_sel_out, err_out
//   raymarcher    : rm_x_out, rm_y_out, rm_start_out  /  rm_done_in, rm_color_in, rm_x_in, rm_y_in
//   frame buffer  : fb_addr_out, fb_data_out, fb_we_out
// master = scheduler side, slave = environment (raymarcher, frame buffer, host).
interface ray_pixel_scheduler_if
  import raymarch_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic               frame_start_in;
  logic               busy_out;
  logic               frame_done_out;
  logic               buffer_sel_out;
  logic               err_out;
  logic [COORD_W-1:0] rm_x_out;
  logic [COORD_W-1:0] rm_y_out;
  logic               rm_start_out;
  logic               rm_done_in;
  logic [23:0]        rm_color_in;
  logic [COORD_W-1:0] rm_x_in;
  logic [COORD_W-1:0] rm_y_in;
  logic [ADDR_W-1:0]  fb_addr_out;
  logic [15:0]        fb_data_out;
  logic               fb_we_out;

  modport master (
    input  frame_start_in, rm_done_in, rm_color_in, rm_x_in, rm_y_in,
    output busy_out, frame_done_out, buffer_sel_out, err_out,
           rm_x_out, rm_y_out, rm_start_out,
           fb_addr_out, fb_data_out, fb_we_out
  );

  modport slave (
    output frame_start_in, rm_done_in, rm_color_in, rm_x_in, rm_y_in,
    input  busy_out, frame_done_out, buffer_sel_out, err_out,
           rm_x_out, rm_y_out, rm_start_out,
           fb_addr_out, fb_data_out, fb_we_out
  );

endinterface

// File: rtl/ray_pixel_scheduler.sv
// Frame sequencer in front of the raymarcher. Walks a WIDTH x HEIGHT frame in
// raster order; for each pixel it pulses rm_start_out with the coordinate, waits
// for the raymarcher's done (with a watchdog), packs the colour to RGB565 and
// writes it to the frame buffer at a running address. Double-buffer select
// toggles at every frame end.
// Ports:
//   clk_in  : system clock
//   rst_in  : synchronous, active-high reset
//   bus     : ray_pixel_scheduler_if.master (frame control, raymarcher, frame buffer)
// All outputs are registered.
module ray_pixel_scheduler
  import raymarch_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 180,
  parameter int TIMEOUT = 65535,
  parameter int ADDR_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  ray_pixel_scheduler_if.master bus
);

  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(HEIGHT - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(TIMEOUT);

  sched_state_t       r_state;
  sched_state_t       w_next_state;

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [ADDR_W-1:0]  r_addr;
  logic [WDOG_W-1:0]  r_wdog;
  logic [15:0]        r_data;
  logic               r_start;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_we;
  logic               r_buf_sel;
  logic               r_err;

  logic               w_done_ok;
  logic               w_timeout;
  logic               w_last_pixel;
  logic               w_echo_bad;
  logic               w_start_nxt;
  logic               w_busy_nxt;
  logic               w_frame_done_nxt;
  logic               w_we_nxt;

  // The watchdog counter is 0 only in the first WAIT cycle, so a done still
  // held over from the previous pixel is ignored there.
  assign w_done_ok    = (r_state == ST_WAIT) && bus.rm_done_in && (r_wdog != '0);
  assign w_timeout    = (r_state == ST_WAIT) && !w_done_ok && (r_wdog >= WDOG_LIMIT);
  assign w_last_pixel = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_echo_bad   = (bus.rm_x_in != r_x) || (bus.rm_y_in != r_y);

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block and has priority over everything else.
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.frame_start_in) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  if (w_done_ok || w_timeout) w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = w_last_pixel ? ST_DONE : ST_ISSUE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state; registered below so every strobe lines
  // up exactly with the state it belongs to.
  always_comb begin
    w_start_nxt      = (w_next_state == ST_ISSUE);
    w_busy_nxt       = (w_next_state != ST_IDLE);
    w_frame_done_nxt = (w_next_state == ST_DONE);
    w_we_nxt         = (w_next_state == ST_WRITE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_wdog       <= '0;
      r_data       <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_we         <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values from before this edge.
      r_start      <= w_start_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_we         <= w_we_nxt;

      unique case (r_state)
        ST_IDLE: begin
          if (bus.frame_start_in) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
          end
        end
        ST_ISSUE: r_wdog <= '0;
        ST_WAIT: begin
          if (r_wdog != '1) r_wdog <= r_wdog + WDOG_W'(1);
          // Colour and echo are captured here so they are stable for WRITE;
          // a bad echo still writes the pixel at the issued address.
          if (w_done_ok) begin
            r_data <= rgb888_to_565(bus.rm_color_in);
            if (w_echo_bad) r_err <= 1'b1;
          end else if (w_timeout) begin
            r_data <= rgb888_to_565(COLOR_MAGENTA);
            r_err  <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + COORD_W'(1);
          end else begin
            r_x <= r_x + COORD_W'(1);
          end
        end
        ST_DONE:  r_buf_sel <= ~r_buf_sel;
        default:  ;
      endcase
    end
  end

  assign bus.busy_out       = r_busy;
  assign bus.frame_done_out = r_frame_done;
  assign bus.buffer_sel_out = r_buf_sel;
  assign bus.err_out        = r_err;
  assign bus.rm_x_out       = r_x;
  assign bus.rm_y_out       = r_y;
  assign bus.rm_start_out   = r_start;
  assign bus.fb_addr_out    = r_addr;
  assign bus.fb_data_out    = r_data;
  assign bus.fb_we_out      = r_we;

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// Bench for ray_pixel_scheduler on a 4x3 frame with a behavioural raymarcher
// (latency 5, colour {x,y,8'h80}) and a write/issue log checked against a
// raster-order reference computed here.
module tb_ray_pixel_scheduler;
  import raymarch_pkg::*;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int TO   = 20;
  localparam int LAT  = 5;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int BUDGET = 1000;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  ray_pixel_scheduler_if #(.ADDR_W(AW)) bus ();

  ray_pixel_scheduler #(
    .WIDTH(W), .HEIGHT(H), .TIMEOUT(TO), .ADDR_W(AW)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done_pulses = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Write / issue logs.
  int          wq_addr[$];
  logic [15:0] wq_data[$];
  logic        wq_err[$];
  logic        wq_sel[$];
  int          wq_cyc[$];
  int          iq_idx[$];
  int          iq_cyc[$];

  always @(negedge clk_in) begin
    if (bus.fb_we_out === 1'b1) begin
      wq_addr.push_back(int'(bus.fb_addr_out));
      wq_data.push_back(bus.fb_data_out);
      wq_err.push_back(bus.err_out);
      wq_sel.push_back(bus.buffer_sel_out);
      wq_cyc.push_back(cyc);
    end
    if (bus.rm_start_out === 1'b1) begin
      iq_idx.push_back(int'(bus.rm_y_out) * W + int'(bus.rm_x_out));
      iq_cyc.push_back(cyc);
    end
    if (bus.frame_done_out === 1'b1) n_done_pulses++;
  end

  // Behavioural raymarcher.
  bit mdl_level = 1'b0;  // hold done high until the start after it is seen
  int mdl_drop  = -1;    // pixel index whose done is never returned
  int mdl_bad   = -1;    // pixel index whose echoed y is corrupted
  int mdl_cnt   = 0;
  int mdl_stale = 0;
  int mdl_px    = 0;
  int mdl_py    = 0;
  int mdl_idx   = 0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      mdl_cnt = 0;
      mdl_stale = 0;
      bus.rm_done_in  = 1'b0;
      bus.rm_color_in = '0;
      bus.rm_x_in     = '0;
      bus.rm_y_in     = '0;
    end else begin
      if (!mdl_level) bus.rm_done_in = 1'b0;
      if (mdl_stale > 0) begin
        mdl_stale--;
        if (mdl_stale == 0) bus.rm_done_in = 1'b0;
      end
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0 && mdl_idx != mdl_drop) begin
          bus.rm_done_in  = 1'b1;
          bus.rm_color_in = {8'(mdl_px), 8'(mdl_py), 8'h80};
          bus.rm_x_in     = 33'(mdl_px);
          bus.rm_y_in     = (mdl_idx == mdl_bad) ? 33'(mdl_py ^ 1) : 33'(mdl_py);
        end
      end
      if (bus.rm_start_out === 1'b1) begin
        mdl_px  = int'(bus.rm_x_out);
        mdl_py  = int'(bus.rm_y_out);
        mdl_idx = mdl_py * W + mdl_px;
        mdl_cnt = LAT;
        if (mdl_level) mdl_stale = 2;
      end
    end
  end

  // Reference RGB565 for pixel idx: 5/6/5 bits from integer division.
  function automatic logic [15:0] exp_color(input int idx);
    int x = idx % W;
    int y = idx / W;
    return 16'((x / 8) * 2048 + (y / 4) * 32 + (128 / 8));
  endfunction

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete(); wq_err.delete(); wq_sel.delete(); wq_cyc.delete();
    iq_idx.delete(); iq_cyc.delete();
    n_done_pulses = 0;
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    bus.frame_start_in = 1'b0;
    mdl_level = 1'b0; mdl_drop = -1; mdl_bad = -1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_start();
    repeat ($urandom_range(0, 4)) @(posedge clk_in);
    @(posedge clk_in); #1 bus.frame_start_in = 1'b1;
    @(posedge clk_in); #1 bus.frame_start_in = 1'b0;
  endtask

  // Returns at the negedge on which frame_done_out is seen.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk_in);
      if (bus.frame_done_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    bus.frame_start_in = 1'b1;   // start coincident with reset must be ignored
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if ({bus.busy_out, bus.frame_done_out, bus.buffer_sel_out, bus.err_out, bus.rm_start_out, bus.fb_we_out} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {bus.busy_out, bus.frame_done_out, bus.buffer_sel_out, bus.err_out, bus.rm_start_out, bus.fb_we_out});
    end
    n_checks++;
    if ({bus.rm_x_out, bus.rm_y_out} !== 66'd0) begin
      n_fail++; $display("FAIL reset_coords: got x=%0d y=%0d want 0 0", bus.rm_x_out, bus.rm_y_out);
    end
    n_checks++;
    if ({bus.fb_addr_out, bus.fb_data_out} !== '0) begin
      n_fail++; $display("FAIL reset_fb: got addr=%0d data=%h want 0 0", bus.fb_addr_out, bus.fb_data_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    bus.frame_start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      n_checks++;
      if (bus.busy_out !== 1'b0) begin
        n_fail++; $display("FAIL start_with_reset: busy=%b want 0", bus.busy_out);
      end
    end
    clear_logs();
  endtask

  task automatic test_one_frame();
    bit ok;
    do_reset();
    pulse_start();
    // Stray start well inside the frame: must be dropped.
    repeat ($urandom_range(3, 50)) @(posedge clk_in);
    #1 bus.frame_start_in = 1'b1;
    @(posedge clk_in); #1 bus.frame_start_in = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL one_frame_done: no frame_done within %0d cycles", BUDGET); end
    n_checks++;
    if (bus.busy_out !== 1'b1) begin n_fail++; $display("FAIL one_frame_busy_at_done: got %b want 1", bus.busy_out); end
    @(negedge clk_in);
    n_checks++;
    if (wq_addr.size() != NPIX) begin n_fail++; $display("FAIL one_frame_count: got %0d writes want %0d", wq_addr.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wq_addr.size(); i++) begin
      n_checks++;
      if (wq_addr[i] != i || wq_data[i] !== exp_color(i)) begin
        n_fail++; $display("FAIL one_frame_write%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wq_addr[i], wq_data[i], i, exp_color(i));
      end
    end
    if (wq_data.size() > 6) begin
      n_checks++;
      if (wq_data[6] !== 16'h0010) begin n_fail++; $display("FAIL pixel_2_1: got %h want 0010", wq_data[6]); end
    end
    n_checks++;
    if (bus.buffer_sel_out !== 1'b1 || bus.err_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      n_fail++; $display("FAIL one_frame_end: sel=%b err=%b busy=%b want 1 0 0", bus.buffer_sel_out, bus.err_out, bus.busy_out);
    end
    repeat (10) @(negedge clk_in);
    n_checks++;
    if (n_done_pulses != 1 || wq_addr.size() != NPIX) begin
      n_fail++; $display("FAIL one_frame_single: done_pulses=%0d writes=%0d want 1 %0d", n_done_pulses, wq_addr.size(), NPIX);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    mdl_drop = 1;   // pixel (1,0)
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wdog_done: no frame_done within %0d cycles", BUDGET); end
    @(negedge clk_in);
    n_checks++;
    if (wq_addr.size() != NPIX) begin n_fail++; $display("FAIL wdog_count: got %0d writes want %0d", wq_addr.size(), NPIX); end
    if (wq_addr.size() > 1 && iq_cyc.size() > 1) begin
      n_checks++;
      if (wq_addr[1] != 1 || wq_data[1] !== 16'hF81F) begin
        n_fail++; $display("FAIL wdog_data: got addr=%0d data=%h want 1 f81f", wq_addr[1], wq_data[1]);
      end
      n_checks++;
      if (wq_cyc[1] - iq_cyc[1] != TO + 2) begin
        n_fail++; $display("FAIL wdog_latency: got %0d cycles want %0d", wq_cyc[1] - iq_cyc[1], TO + 2);
      end
      n_checks++;
      if (wq_err[0] !== 1'b0 || wq_err[1] !== 1'b1) begin
        n_fail++; $display("FAIL wdog_err_timing: got %b%b want 01", wq_err[0], wq_err[1]);
      end
    end
    for (int i = 2; i < wq_addr.size(); i++) begin
      n_checks++;
      if (wq_addr[i] != i || wq_data[i] !== exp_color(i)) begin
        n_fail++; $display("FAIL wdog_write%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wq_addr[i], wq_data[i], i, exp_color(i));
      end
    end
    n_checks++;
    if (bus.err_out !== 1'b1) begin n_fail++; $display("FAIL wdog_err_sticky: got %b want 1", bus.err_out); end
  endtask

  task automatic test_echo_error();
    bit ok;
    int bad;
    do_reset();
    bad = int'($urandom_range(0, NPIX - 1));
    mdl_bad = bad;
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL echo_done: no frame_done within %0d cycles", BUDGET); end
    @(negedge clk_in);
    n_checks++;
    if (wq_addr.size() != NPIX) begin n_fail++; $display("FAIL echo_count: got %0d writes want %0d", wq_addr.size(), NPIX); end
    for (int i = 0; i < wq_addr.size(); i++) begin
      n_checks++;
      if (wq_addr[i] != i || wq_data[i] !== exp_color(i) || wq_err[i] !== (i >= bad)) begin
        n_fail++; $display("FAIL echo_write%0d: got addr=%0d data=%h err=%b want addr=%0d data=%h err=%b (bad pixel %0d)",
                           i, wq_addr[i], wq_data[i], wq_err[i], i, exp_color(i), (i >= bad), bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    do_reset();
    @(posedge clk_in); #1 bus.frame_start_in = 1'b1;
    wait_done(ok1);
    wait_done(ok2);
    bus.frame_start_in = 1'b0;   // lowered before the IDLE cycle samples it
    n_checks++;
    if (!ok1 || !ok2) begin n_fail++; $display("FAIL b2b_done: frames completed %0d%0d want 11", ok1, ok2); end
    @(negedge clk_in);
    n_checks++;
    if (bus.buffer_sel_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: sel=%b busy=%b want 0 0", bus.buffer_sel_out, bus.busy_out);
    end
    n_checks++;
    if (wq_addr.size() != 2 * NPIX || iq_idx.size() != 2 * NPIX) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes %0d issues want %0d", wq_addr.size(), iq_idx.size(), 2 * NPIX);
    end
    for (int i = 0; i < wq_addr.size() && i < iq_idx.size(); i++) begin
      n_checks++;
      if (wq_addr[i] != i % NPIX || iq_idx[i] != i % NPIX || wq_data[i] !== exp_color(i % NPIX) || wq_sel[i] !== (i >= NPIX)) begin
        n_fail++; $display("FAIL b2b_write%0d: got addr=%0d issue=%0d data=%h sel=%b want %0d %0d %h %b",
                           i, wq_addr[i], iq_idx[i], wq_data[i], wq_sel[i], i % NPIX, i % NPIX, exp_color(i % NPIX), (i >= NPIX));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok, seen;
    do_reset();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk_in);
      if (bus.rm_start_out === 1'b1 && bus.rm_x_out == 33'd1 && bus.rm_y_out == 33'd1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_issue5: pixel 5 never issued"); end
    @(posedge clk_in); #1;           // first WAIT cycle
    @(posedge clk_in); #1 rst_in = 1'b1;  // second WAIT cycle
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({bus.busy_out, bus.frame_done_out, bus.buffer_sel_out, bus.err_out, bus.rm_start_out, bus.fb_we_out} !== 6'b0 ||
        {bus.rm_x_out, bus.rm_y_out, bus.fb_addr_out, bus.fb_data_out} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: busy=%b we=%b x=%0d y=%0d addr=%0d data=%h want all 0",
                         bus.busy_out, bus.fb_we_out, bus.rm_x_out, bus.rm_y_out, bus.fb_addr_out, bus.fb_data_out);
    end
    repeat (20) @(negedge clk_in);
    n_checks++;
    if (wq_addr.size() != 5 || (wq_addr.size() > 0 && wq_addr[wq_addr.size() - 1] != 4)) begin
      n_fail++; $display("FAIL rst_mid_no_write: got %0d writes want 5 (addrs 0..4)", wq_addr.size());
    end
    clear_logs();
    pulse_start();
    wait_done(ok);
    @(negedge clk_in);
    n_checks++;
    if (!ok || wq_addr.size() != NPIX) begin
      n_fail++; $display("FAIL rst_mid_restart: done=%0d writes=%0d want 1 %0d", ok, wq_addr.size(), NPIX);
    end
    for (int i = 0; i < wq_addr.size(); i++) begin
      n_checks++;
      if (wq_addr[i] != i || wq_data[i] !== exp_color(i)) begin
        n_fail++; $display("FAIL rst_mid_write%0d: got addr=%0d data=%h want %0d %h", i, wq_addr[i], wq_data[i], i, exp_color(i));
      end
    end
  endtask

  task automatic test_level_done();
    bit ok;
    do_reset();
    mdl_level = 1'b1;
    pulse_start();
    wait_done(ok);
    @(negedge clk_in);
    n_checks++;
    if (!ok || wq_addr.size() != NPIX || bus.err_out !== 1'b0) begin
      n_fail++; $display("FAIL level_frame: done=%0d writes=%0d err=%b want 1 %0d 0", ok, wq_addr.size(), bus.err_out, NPIX);
    end
    for (int i = 0; i < wq_addr.size() && i < iq_cyc.size(); i++) begin
      n_checks++;
      if (wq_addr[i] != i || wq_data[i] !== exp_color(i) || wq_cyc[i] - iq_cyc[i] != LAT + 1) begin
        n_fail++; $display("FAIL level_write%0d: got addr=%0d data=%h lat=%0d want %0d %h %0d",
                           i, wq_addr[i], wq_data[i], wq_cyc[i] - iq_cyc[i], i, exp_color(i), LAT + 1);
      end
    end
  endtask

  initial begin
    rst_in = 1'b1;
    bus.frame_start_in = 1'b0;
    test_reset();
    test_one_frame();
    test_watchdog();
    test_echo_error();
    test_back_to_back();
    test_reset_mid_wait();
    test_level_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish by %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ray_pixel_scheduler.md
# ray_pixel_scheduler

Frame-level sequencer directly upstream of `raymarcher`. It walks every pixel of a WIDTH×HEIGHT frame, and for each one issues the pixel coordinate with a start pulse, then waits for `pixel_done`. It packs the returned 24-bit colour to RGB565 and writes it into a double-buffered frame buffer. It also handles frame request/completion, a per-pixel watchdog and coordinate-echo checking.

## Interface
Parameters:
- `WIDTH`, 320, pixels per row.
- `HEIGHT`, 180, rows per frame.
- `TIMEOUT`, 65535, max WAIT cycles per pixel before the watchdog fires.
- `ADDR_W`, $clog2(WIDTH*HEIGHT), frame-buffer address width.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `frame_start_in`  in  1  request one frame; honoured only in IDLE.
- `busy_out`  out  1  high in every state except IDLE.
- `frame_done_out`  out  1  one-cycle pulse at end of frame.
- `buffer_sel_out`  out  1  buffer being rendered; toggles at frame end.
- `err_out`  out  1  sticky: watchdog or coordinate mismatch; cleared only by reset.
- `rm_x_out`, `rm_y_out`  out  33  pixel coordinate to raymarcher `curr_x`/`curr_y`.
- `rm_start_out`  out  1  to raymarcher `start_in`.
- `rm_done_in`  in  1  raymarcher `pixel_done`.
- `rm_color_in`  in  24  {R[23:16],G[15:8],B[7:0]}.
- `rm_x_in`, `rm_y_in`  in  33  raymarcher `out_x`/`out_y` echo.
- `fb_addr_out`  out  ADDR_W  write address within selected buffer.
- `fb_data_out`  out  16  RGB565.
- `fb_we_out`  out  1  write strobe.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: on `frame_start_in`, set x=0, y=0, addr=0, go to ISSUE.
- ISSUE: assert `rm_start_out` for exactly one cycle. `rm_x_out`/`rm_y_out` already hold x/y and stay stable until the next ISSUE. Clear the watchdog counter, then go to WAIT.
- WAIT: ignore `rm_done_in` in the first WAIT cycle; this guards against a level-held done from the previous pixel. From the second cycle on, `rm_done_in`=1 captures colour and echo coordinates, then go to WRITE. If the counter reaches TIMEOUT, capture magenta 24'hFF00FF, set `err_out`, and go to WRITE.
- WRITE: `fb_we_out`=1 for one cycle. `fb_addr_out`=addr. `fb_data_out`={R[7:3],G[7:2],B[7:3]}. If the echo ≠ issued x/y (non-watchdog case), set `err_out`; the pixel is still written at the issued address.
- Advance after WRITE: addr+1. If x==WIDTH-1, x=0 and y+1, else x+1. If the pixel just written was x==WIDTH-1 and y==HEIGHT-1, go to DONE, else go to ISSUE.
- DONE: pulse `frame_done_out`, toggle `buffer_sel_out`, go to IDLE.
- Address comes from a running counter, not a y*WIDTH multiply.
- Reset in any state: go to IDLE immediately. The in-flight pixel is abandoned and nothing is written.

## Timing
- Reset values: all outputs 0, including `buffer_sel_out`, `err_out` and the coordinates.
- All outputs are registered.
- Per-pixel overhead: ISSUE(1) + WAIT(≥2) + WRITE(1), so at least 4 cycles plus raymarcher latency.
- `frame_done_out` is asserted the cycle after the last WRITE. `busy_out` drops the cycle after that.
- `frame_start_in` during a busy state is dropped, not queued.
- `frame_start_in` in the same cycle as `rst_in` is ignored.
- Watchdog counter is 17 bits and saturates.

## Structure
- Shared package `raymarch_pkg`: state enum `sched_state_t`, `COORD_W`=33, `COLOR_MAGENTA`, and an `rgb888_to_565` function.
- No sub-module. One optional instance, `wdog_counter`, if the team prefers the watchdog split out.

## Test plan
Bench settings for all scenarios: WIDTH=4, HEIGHT=3, TIMEOUT=20, behavioural raymarcher model with latency 5 returning colour {x,y,8'h80}.

1. One frame: `frame_start_in` pulse -> 12 writes at addrs 0..11 in raster order. Pixel (2,1) gives data {5'h00,6'h00,5'h10}. Then one `frame_done_out` pulse, `buffer_sel_out`=1, `err_out`=0.
2. Model drops done for pixel (1,0) -> write at addr 1 of 16'hF81F exactly 22 cycles after that ISSUE. `err_out`=1; frame still completes with 12 writes.
3. Model echoes wrong y for one pixel -> `err_out` set in that WRITE cycle; data is written at the issued address.
4. `frame_start_in` held high throughout -> back-to-back frames; `buffer_sel_out` toggles 0→1→0. A start during busy never restarts x/y.
5. `rst_in` pulsed mid-WAIT of pixel 5 -> next cycle IDLE with all outputs 0 and no write for pixel 5. A new start renders from addr 0.
6. Model holds `pixel_done` level-high between pixels -> the stale done is not accepted in the first WAIT cycle, and exactly 12 writes occur.
